// File: rtl/bus_demux_reg_if.sv
// Source-to-channel handshake bundle for bus_demux_reg.
// The source drives in_* and out_ready; the block answers with in_ready, channel outputs and drop status.
interface bus_demux_reg_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NCH   = 16,
  parameter int unsigned SELW  = 4
);
  logic [WIDTH-1:0]     in_data;
  logic [SELW-1:0]      in_sel;
  logic                 in_bcast;
  logic                 in_valid;
  logic                 in_ready;
  logic [NCH*WIDTH-1:0] out_data;
  logic [NCH-1:0]       out_valid;
  logic [NCH-1:0]       out_ready;
  logic                 err_sel;
  logic [7:0]           drop_cnt;

  modport master (
    output in_data, in_sel, in_bcast, in_valid, out_ready,
    input  in_ready, out_data, out_valid, err_sel, drop_cnt
  );

  modport slave (
    input  in_data, in_sel, in_bcast, in_valid, out_ready,
    output in_ready, out_data, out_valid, err_sel, drop_cnt
  );
endinterface

// File: rtl/bus_demux_reg.sv
// One-to-NCH registered demultiplexer with unicast, all-or-nothing broadcast,
// per-channel ready/valid output registers and out-of-range select drop accounting.
module bus_demux_reg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NCH   = 16,
  parameter int unsigned SELW  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  bus_demux_reg_if.slave     bus
);

  localparam int unsigned DW = NCH * WIDTH;

  logic [NCH-1:0] hit_c;
  logic [NCH-1:0] free_c;
  logic [NCH-1:0] load_c;
  logic           rdy_c;
  logic           acc_c;
  logic           drop_c;

  logic [NCH-1:0] valid_q;
  logic [DW-1:0]  data_q;
  logic           err_q;
  logic [7:0]     cnt_q;

  // Acceptance decode; a channel is free when empty or draining this edge.
  always_comb begin
    hit_c  = '0;
    rdy_c  = 1'b0;
    load_c = '0;
    drop_c = 1'b0;
    for (int unsigned k = 0; k < NCH; k++) begin
      hit_c[k] = (32'(bus.in_sel) == k);
    end
    free_c = ~valid_q | bus.out_ready;
    if (rst_n) begin
      if (bus.in_bcast)  rdy_c = &free_c;
      else if (|hit_c)   rdy_c = |(hit_c & free_c);
      else               rdy_c = 1'b1;
    end
    acc_c = bus.in_valid & rdy_c;
    if (acc_c) begin
      if (bus.in_bcast)  load_c = '1;
      else if (|hit_c)   load_c = hit_c;
      else               drop_c = 1'b1;
    end
  end

  // Channel registers: a load on the draining edge replaces the outgoing word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      for (int unsigned k = 0; k < NCH; k++) begin
        if (load_c[k]) begin
          data_q[k*WIDTH +: WIDTH] <= bus.in_data;
          valid_q[k]               <= 1'b1;
        end else if (bus.out_ready[k]) begin
          valid_q[k] <= 1'b0;
        end
      end
      err_q <= drop_c;
      if (drop_c && (cnt_q != 8'hFF)) cnt_q <= cnt_q + 8'd1;
    end
  end

  assign bus.in_ready  = rdy_c;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.err_sel   = err_q;
  assign bus.drop_cnt  = cnt_q;

endmodule

// File: tb/tb_bus_demux_reg.sv
// Bench for bus_demux_reg: a 16-channel and a 12-channel instance share one stimulus
// stream and are each compared every cycle against an array-based channel model.
module tb_bus_demux_reg;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [7:0]  s_data;
  logic [3:0]  s_sel;
  logic        s_bcast;
  logic        s_valid;
  logic [15:0] s_ordy;

  bus_demux_reg_if #(.WIDTH(8), .NCH(16), .SELW(4)) b16 ();
  bus_demux_reg_if #(.WIDTH(8), .NCH(12), .SELW(4)) b12 ();

  assign b16.in_data   = s_data;
  assign b16.in_sel    = s_sel;
  assign b16.in_bcast  = s_bcast;
  assign b16.in_valid  = s_valid;
  assign b16.out_ready = s_ordy;
  assign b12.in_data   = s_data;
  assign b12.in_sel    = s_sel;
  assign b12.in_bcast  = s_bcast;
  assign b12.in_valid  = s_valid;
  assign b12.out_ready = s_ordy[11:0];

  bus_demux_reg #(.WIDTH(8), .NCH(16), .SELW(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));
  bus_demux_reg #(.WIDTH(8), .NCH(12), .SELW(4)) dut12 (.clk(clk), .rst_n(rst_n), .bus(b12));

  int checks = 0;
  int errors = 0;

  // Reference model: index 0 is the 16-channel block, index 1 the 12-channel one.
  int         nchs [2] = '{16, 12};
  logic       mv   [2][16];
  logic [7:0] md   [2][16];
  int         mcnt [2];
  logic       merr [2];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic exp_rdy(input int d);
    logic all_free;
    if (!rst_n) return 1'b0;
    if (s_bcast) begin
      all_free = 1'b1;
      for (int k = 0; k < nchs[d]; k++) if (mv[d][k] && !s_ordy[k]) all_free = 1'b0;
      return all_free;
    end
    if (int'(s_sel) >= nchs[d]) return 1'b1;
    return !mv[d][s_sel] || s_ordy[s_sel];
  endfunction

  task automatic model_edge(input int d);
    logic acc;
    if (!rst_n) begin
      for (int k = 0; k < 16; k++) begin mv[d][k] = 1'b0; md[d][k] = 8'h00; end
      mcnt[d] = 0;
      merr[d] = 1'b0;
      return;
    end
    acc = s_valid && exp_rdy(d);
    for (int k = 0; k < nchs[d]; k++) begin
      if (acc && (s_bcast || int'(s_sel) == k)) begin
        md[d][k] = s_data;
        mv[d][k] = 1'b1;
      end else if (s_ordy[k]) begin
        mv[d][k] = 1'b0;
      end
    end
    merr[d] = acc && !s_bcast && (int'(s_sel) >= nchs[d]);
    if (merr[d] && mcnt[d] < 255) mcnt[d]++;
  endtask

  task automatic check_model(input string tag);
    logic [15:0]  ev16;
    logic [127:0] ed16;
    logic [11:0]  ev12;
    logic [95:0]  ed12;
    for (int k = 0; k < 16; k++) begin ev16[k] = mv[0][k]; ed16[k*8 +: 8] = md[0][k]; end
    for (int k = 0; k < 12; k++) begin ev12[k] = mv[1][k]; ed12[k*8 +: 8] = md[1][k]; end
    chk({tag, " rdy16"},  128'(b16.in_ready),  128'(exp_rdy(0)));
    chk({tag, " v16"},    128'(b16.out_valid), 128'(ev16));
    chk({tag, " d16"},    b16.out_data,        ed16);
    chk({tag, " err16"},  128'(b16.err_sel),   128'(merr[0]));
    chk({tag, " cnt16"},  128'(b16.drop_cnt),  128'(mcnt[0]));
    chk({tag, " rdy12"},  128'(b12.in_ready),  128'(exp_rdy(1)));
    chk({tag, " v12"},    128'(b12.out_valid), 128'(ev12));
    chk({tag, " d12"},    128'(b12.out_data),  128'(ed12));
    chk({tag, " err12"},  128'(b12.err_sel),   128'(merr[1]));
    chk({tag, " cnt12"},  128'(b12.drop_cnt),  128'(mcnt[1]));
  endtask

  // Inputs are already set; check pre-edge view, then advance one clock.
  task automatic cycle(input string tag);
    #1;
    check_model(tag);
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
  endtask

  task automatic drive(input logic v, input logic bc, input logic [3:0] sel,
                       input logic [7:0] dat, input logic [15:0] ordy);
    s_valid = v; s_bcast = bc; s_sel = sel; s_data = dat; s_ordy = ordy;
  endtask

  typedef struct {
    logic        valid;
    logic        bcast;
    logic [3:0]  sel;
    logic [7:0]  data;
    logic [15:0] ordy;
    logic        exp_rdy;
    logic [15:0] exp_v;
  } vec_t;

  vec_t vecs [18];

  initial begin
    // Unicast streaming to channel 5
    vecs[0]  = '{1'b1, 1'b0, 4'd5, 8'hA5, 16'hFFFF, 1'b1, 16'h0020};
    vecs[1]  = '{1'b1, 1'b0, 4'd5, 8'hA6, 16'hFFFF, 1'b1, 16'h0020};
    vecs[2]  = '{1'b1, 1'b0, 4'd5, 8'hA7, 16'hFFFF, 1'b1, 16'h0020};
    vecs[3]  = '{1'b0, 1'b0, 4'd5, 8'h00, 16'hFFFF, 1'b1, 16'h0000};
    // Stall on channel 3, second word loads on the draining edge
    vecs[4]  = '{1'b1, 1'b0, 4'd3, 8'h11, 16'hFFF7, 1'b1, 16'h0008};
    vecs[5]  = '{1'b1, 1'b0, 4'd3, 8'h22, 16'hFFF7, 1'b0, 16'h0008};
    vecs[6]  = '{1'b1, 1'b0, 4'd3, 8'h22, 16'hFFF7, 1'b0, 16'h0008};
    vecs[7]  = '{1'b1, 1'b0, 4'd3, 8'h22, 16'hFFFF, 1'b1, 16'h0008};
    vecs[8]  = '{1'b0, 1'b0, 4'd3, 8'h00, 16'hFFFF, 1'b1, 16'h0000};
    // Broadcast blocked by stalled channel 7, then all-or-nothing load
    vecs[9]  = '{1'b1, 1'b0, 4'd7, 8'h77, 16'hFF7F, 1'b1, 16'h0080};
    vecs[10] = '{1'b1, 1'b1, 4'd0, 8'h3C, 16'hFF7F, 1'b0, 16'h0080};
    vecs[11] = '{1'b1, 1'b1, 4'd0, 8'h3C, 16'hFFFF, 1'b1, 16'hFFFF};
    vecs[12] = '{1'b0, 1'b0, 4'd0, 8'h00, 16'h0000, 1'b0, 16'hFFFF};
    vecs[13] = '{1'b0, 1'b0, 4'd0, 8'h00, 16'hFFFF, 1'b1, 16'h0000};
    // Stalled channel 2 does not block channel 9
    vecs[14] = '{1'b1, 1'b0, 4'd2, 8'h12, 16'hFFFB, 1'b1, 16'h0004};
    vecs[15] = '{1'b1, 1'b0, 4'd9, 8'h99, 16'hFFFB, 1'b1, 16'h0204};
    vecs[16] = '{1'b1, 1'b0, 4'd2, 8'h13, 16'hFFFB, 1'b0, 16'h0004};
    vecs[17] = '{1'b0, 1'b0, 4'd2, 8'h00, 16'hFFFF, 1'b1, 16'h0000};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 8'h00, 16'h0000);
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    drive(1'b1, 1'b0, 4'd5, 8'hA5, 16'hFFFF);
    #1;
    chk("reset rdy16", 128'(b16.in_ready), 128'(1'b0));
    chk("reset v16",   128'(b16.out_valid), 128'(16'h0000));
    chk("reset cnt16", 128'(b16.drop_cnt),  128'(8'd0));
    cycle("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].valid, vecs[i].bcast, vecs[i].sel, vecs[i].data, vecs[i].ordy);
      #1;
      chk($sformatf("vec%0d rdy", i), 128'(b16.in_ready), 128'(vecs[i].exp_rdy));
      #1;
      @(posedge clk);
      model_edge(0);
      model_edge(1);
      #1;
      chk($sformatf("vec%0d v", i), 128'(b16.out_valid), 128'(vecs[i].exp_v));
      check_model($sformatf("vec%0d", i));
    end
    chk("bcast data ch15", 128'(b16.out_data[127:120]), 128'(8'h3C));

    // Out-of-range select on the 12-channel block
    drive(1'b1, 1'b0, 4'd13, 8'h5A, 16'hFFFF);
    #1;
    chk("oor rdy12", 128'(b12.in_ready), 128'(1'b1));
    chk("oor cnt before", 128'(b12.drop_cnt), 128'(8'd0));
    cycle("oor0");
    chk("oor err pulse", 128'(b12.err_sel), 128'(1'b1));
    chk("oor cnt after", 128'(b12.drop_cnt), 128'(8'd1));
    chk("oor v12 kept", 128'(b12.out_valid), 128'(12'h000));
    drive(1'b0, 1'b0, 4'd13, 8'h00, 16'hFFFF);
    cycle("oor1");
    chk("oor err end", 128'(b12.err_sel), 128'(1'b0));
    drive(1'b1, 1'b0, 4'd14, 8'hEE, 16'hFFFF);
    for (int i = 0; i < 300; i++) cycle("oor sat");
    chk("oor saturate", 128'(b12.drop_cnt), 128'(8'd255));
    drive(1'b1, 1'b1, 4'd13, 8'h44, 16'hFFFF);
    cycle("bcast oor");
    chk("bcast no err", 128'(b12.err_sel), 128'(1'b0));
    chk("bcast v12", 128'(b12.out_valid), 128'(12'hFFF));

    // Mid-operation reset with channels 0..7 held
    drive(1'b0, 1'b0, 4'd0, 8'h00, 16'hFFFF);
    cycle("drain");
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 1'b0, 4'(k), 8'(k + 1), 16'h0000);
      cycle("fill");
    end
    chk("fill v16", 128'(b16.out_valid), 128'(16'h00FF));
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 4'd8, 8'h88, 16'h0000);
    #1;
    chk("rst rdy16", 128'(b16.in_ready), 128'(1'b0));
    chk("rst rdy12", 128'(b12.in_ready), 128'(1'b0));
    cycle("rst");
    chk("rst v16",   128'(b16.out_valid), 128'(16'h0000));
    chk("rst d16",   b16.out_data, 128'(0));
    chk("rst cnt12", 128'(b12.drop_cnt), 128'(8'd0));
    rst_n = 1'b1;
    #1;
    chk("release rdy16", 128'(b16.in_ready), 128'(1'b1));
    cycle("release");
    chk("release v16", 128'(b16.out_valid), 128'(16'h0100));
    chk("release d8",  128'(b16.out_data[71:64]), 128'(8'h88));

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst_n   = ($urandom_range(0, 99) != 0);
      s_valid = ($urandom_range(0, 3) != 0);
      s_bcast = ($urandom_range(0, 7) == 0);
      s_sel   = 4'($urandom_range(0, 15));
      s_data  = 8'($urandom);
      s_ordy  = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      cycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
